// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: walks memory, checks each word through an external
// SECDED decoder, writes back corrected single-bit errors, flags double errors.
module ecc_scrub_ctrl #(
   parameter int K   = 8,
   parameter int M   = 4,
   parameter int AW  = 6,
   parameter int GAP = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   output logic          busy_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [K+M:0]  mem_wdata_o,
   input  logic          mem_gnt_i,
   input  logic          mem_rvalid_i,
   input  logic [K+M:0]  mem_rdata_i,
   output logic [K+M:0]  dec_code_o,
   input  logic [K-1:0]  dec_data_i,
   input  logic          dec_sb_err_i,
   input  logic          dec_db_err_i,
   output logic [K-1:0]  enc_data_o,
   input  logic [K+M:0]  enc_code_i,
   output logic [15:0]   sb_cnt_o,
   output logic [15:0]   db_cnt_o,
   output logic [AW-1:0] db_addr_o,
   output logic          db_irq_o
);

   localparam int N  = K + M + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT
   } state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] gap_q;
   logic [AW-1:0] addr_q;
   logic [N-1:0]  code_q;
   logic [N-1:0]  wr_q;

   logic gap_clr, gap_inc;
   logic cap_rd, cap_wr;
   logic hit_sb, hit_db;
   logic adv;

   always_comb begin
      state_d   = state_q;
      gap_clr   = 1'b0;
      gap_inc   = 1'b0;
      cap_rd    = 1'b0;
      cap_wr    = 1'b0;
      hit_sb    = 1'b0;
      hit_db    = 1'b0;
      adv       = 1'b0;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!en_i) begin
               gap_clr = 1'b1;
            end else if (gap_q == GAP_LAST) begin
               gap_clr = 1'b1;
               state_d = RD_REQ;
            end else begin
               gap_inc = 1'b1;
            end
         end
         RD_REQ: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rvalid_i) begin
               cap_rd  = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            // a double error is never written back, even if sb is also set
            if (dec_db_err_i) begin
               hit_db  = 1'b1;
               state_d = NEXT;
            end else if (dec_sb_err_i) begin
               hit_sb  = 1'b1;
               cap_wr  = 1'b1;
               state_d = WR_REQ;
            end else begin
               state_d = NEXT;
            end
         end
         WR_REQ: begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            if (mem_gnt_i) state_d = NEXT;
         end
         NEXT: begin
            adv     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         gap_q     <= '0;
         addr_q    <= '0;
         code_q    <= '0;
         wr_q      <= '0;
         sb_cnt_o  <= '0;
         db_cnt_o  <= '0;
         db_addr_o <= '0;
         db_irq_o  <= 1'b0;
      end else begin
         state_q  <= state_d;
         db_irq_o <= hit_db;
         if (gap_clr) gap_q <= '0;
         else if (gap_inc) gap_q <= gap_q + 1'b1;
         if (cap_rd) code_q <= mem_rdata_i;
         if (cap_wr) wr_q <= enc_code_i;
         if (adv) addr_q <= addr_q + 1'b1;
         if (hit_sb && sb_cnt_o != 16'hFFFF) sb_cnt_o <= sb_cnt_o + 16'd1;
         if (hit_db) begin
            db_addr_o <= addr_q;
            if (db_cnt_o != 16'hFFFF) db_cnt_o <= db_cnt_o + 16'd1;
         end
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wr_q;
   assign dec_code_o  = code_q;
   assign enc_data_o  = dec_data_i;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Bench for ecc_scrub_ctrl: behavioural SECDED codec, memory responder with
// transaction scoreboard, directed vector table and randomized scrubbing.
module tb_ecc_scrub_ctrl;

   localparam int K     = 8;
   localparam int M     = 4;
   localparam int AW    = 4;
   localparam int GAP   = 4;
   localparam int N     = K + M + 1;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          busy;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [N-1:0]  mem_wdata;
   logic          gnt;
   logic          rvalid;
   logic [N-1:0]  rdata;
   logic [N-1:0]  dec_code;
   logic [K-1:0]  dec_data;
   logic          dec_sb;
   logic          dec_db;
   logic [K-1:0]  enc_data;
   logic [N-1:0]  enc_code;
   logic [15:0]   sb_cnt;
   logic [15:0]   db_cnt;
   logic [AW-1:0] db_addr;
   logic          db_irq;

   ecc_scrub_ctrl #(.K(K), .M(M), .AW(AW), .GAP(GAP)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .en_i         (en),
      .busy_o       (busy),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_gnt_i    (gnt),
      .mem_rvalid_i (rvalid),
      .mem_rdata_i  (rdata),
      .dec_code_o   (dec_code),
      .dec_data_i   (dec_data),
      .dec_sb_err_i (dec_sb),
      .dec_db_err_i (dec_db),
      .enc_data_o   (enc_data),
      .enc_code_i   (enc_code),
      .sb_cnt_o     (sb_cnt),
      .db_cnt_o     (db_cnt),
      .db_addr_o    (db_addr),
      .db_irq_o     (db_irq)
   );

   initial forever #5 clk = ~clk;

   // Hamming(12,8): parity at positions 1,2,4,8; bit 0 is overall parity
   function automatic logic [12:0] enc(input logic [7:0] d);
      logic [12:0] c;
      int j;
      c = '0;
      j = 0;
      for (int p = 1; p <= 12; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p] = d[j];
            j++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         logic par;
         par = 1'b0;
         for (int p = 1; p <= 12; p++)
            if (((p >> i) & 1) == 1) par = par ^ c[p];
         c[1 << i] = par;
      end
      c[0] = ^c[12:1];
      return c;
   endfunction

   function automatic logic [9:0] decode(input logic [12:0] c);
      logic [3:0]  syn;
      logic [12:0] f;
      logic [7:0]  d;
      logic        sb;
      logic        db;
      int j;
      syn = '0;
      for (int p = 1; p <= 12; p++)
         if (c[p]) syn = syn ^ 4'(p);
      f  = c;
      sb = 1'b0;
      db = 1'b0;
      if (^c) begin
         sb = 1'b1;
         if (syn <= 4'd12) f[syn] = ~f[syn];
      end else if (syn != 0) begin
         db = 1'b1;
      end
      d = '0;
      j = 0;
      for (int p = 1; p <= 12; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[j] = f[p];
            j++;
         end
      end
      return {d, sb, db};
   endfunction

   always_comb begin
      {dec_data, dec_sb, dec_db} = decode(dec_code);
      enc_code = enc(enc_data);
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // memory image, clean reference and number of flipped bits per word
   logic [N-1:0] mem   [DEPTH];
   logic [N-1:0] clean [DEPTH];
   int           flips [DEPTH];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int gnt_delay = 0;
   int rv_delay  = 0;
   int wait_cnt  = 0;
   int rv_cnt    = 0;
   logic [AW-1:0] rv_addr;
   logic          stab_on = 1'b0;
   logic          cap_we;
   logic [AW-1:0] cap_addr;
   logic [N-1:0]  cap_wdata;

   int   exp_addr = 0;
   int   exp_sb = 0;
   int   exp_db = 0;
   int   exp_dba = 0;
   int   irq_hi_cnt = 0;
   logic expect_write = 1'b0;
   int   cur_addr = 0;
   int   last_rd_addr = -1;
   int   rd_cnt = 0;
   int   wr_cnt = 0;
   int   rd_t [8];

   task automatic grant();
      if (!mem_we) begin
         chk("rd_addr", 32'(mem_addr), exp_addr);
         chk("wr_missing", 32'(expect_write), 0);
         if (rd_cnt < 8) rd_t[rd_cnt] = cyc;
         rd_cnt++;
         cur_addr     = int'(mem_addr);
         last_rd_addr = int'(mem_addr);
         if (flips[mem_addr] == 1) begin
            expect_write = 1'b1;
            exp_sb++;
         end else if (flips[mem_addr] == 2) begin
            exp_db++;
            exp_dba = int'(mem_addr);
         end
         exp_addr = (exp_addr + 1) % DEPTH;
         rv_cnt   = rv_delay + 1;
         rv_addr  = mem_addr;
      end else begin
         wr_cnt++;
         chk("wr_expected", 32'(expect_write), 1);
         chk("wr_addr", 32'(mem_addr), cur_addr);
         chk("wr_data", 32'(mem_wdata), 32'(clean[mem_addr]));
         mem[mem_addr]   = mem_wdata;
         flips[mem_addr] = 0;
         expect_write    = 1'b0;
      end
   endtask

   // memory responder and scoreboard, acting on the falling edge
   initial begin
      gnt    = 1'b0;
      rvalid = 1'b0;
      rdata  = '0;
      forever begin
         @(negedge clk);
         rvalid = 1'b0;
         if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               rvalid = 1'b1;
               rdata  = mem[rv_addr];
            end
         end
         gnt = 1'b0;
         if (!rst_n) begin
            wait_cnt = 0;
            stab_on  = 1'b0;
         end else begin
            if (db_irq) irq_hi_cnt++;
            chk("enc_data", 32'(enc_data), 32'(dec_data));
            if (!busy) begin
               chk("sb_cnt", 32'(sb_cnt), exp_sb);
               chk("db_cnt", 32'(db_cnt), exp_db);
               chk("db_addr", 32'(db_addr), exp_dba);
               chk("irq_cycles", irq_hi_cnt, exp_db);
               chk("idle_req", 32'(mem_req), 0);
            end
            if (mem_req) begin
               if (stab_on) begin
                  chk("stable_we", 32'(mem_we), 32'(cap_we));
                  chk("stable_addr", 32'(mem_addr), 32'(cap_addr));
                  chk("stable_wdata", 32'(mem_wdata), 32'(cap_wdata));
               end else begin
                  stab_on   = 1'b1;
                  cap_we    = mem_we;
                  cap_addr  = mem_addr;
                  cap_wdata = mem_wdata;
               end
               if (wait_cnt >= gnt_delay) begin
                  gnt      = 1'b1;
                  wait_cnt = 0;
                  stab_on  = 1'b0;
                  grant();
               end else begin
                  wait_cnt++;
               end
            end else begin
               wait_cnt = 0;
               stab_on  = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk(nm, 32'(ok), 1);
   endtask

   task automatic inject(input int a, input int fa, input int fb);
      logic [N-1:0] mask;
      mask = '0;
      if (fa >= 0) mask[fa] = 1'b1;
      if (fb >= 0) mask[fb] = 1'b1;
      mem[a]   = clean[a] ^ mask;
      flips[a] = int'(fa >= 0) + int'(fb >= 0);
   endtask

   typedef struct {
      int a;
      int fa;
      int fb;
      int gd;
      int wr;
      int sb;
      int db;
      int dba;
      int fixed;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic ok;
      int   rd0;
      int   wr0;
      int   a;
      int   n;
      int   b0;

      tbl[0] = '{a: 5,  fa: 3,  fb: -1, gd: 0, wr: 1, sb: 1, db: 0, dba: 0,  fixed: 1};
      tbl[1] = '{a: 9,  fa: 2,  fb: 10, gd: 0, wr: 0, sb: 1, db: 1, dba: 9,  fixed: 0};
      tbl[2] = '{a: 2,  fa: -1, fb: -1, gd: 3, wr: 0, sb: 1, db: 1, dba: 9,  fixed: 1};
      tbl[3] = '{a: 7,  fa: 0,  fb: -1, gd: 3, wr: 1, sb: 2, db: 1, dba: 9,  fixed: 1};
      tbl[4] = '{a: 5,  fa: -1, fb: -1, gd: 1, wr: 0, sb: 2, db: 1, dba: 9,  fixed: 1};
      tbl[5] = '{a: 14, fa: 12, fb: 1,  gd: 2, wr: 0, sb: 2, db: 2, dba: 14, fixed: 0};
      tbl[6] = '{a: 15, fa: 12, fb: -1, gd: 0, wr: 1, sb: 3, db: 2, dba: 14, fixed: 1};

      for (int i = 0; i < DEPTH; i++) begin
         clean[i] = enc(8'($urandom_range(0, 255)));
         mem[i]   = clean[i];
         flips[i] = 0;
      end

      rst_n = 1'b0;
      en    = 1'b0;
      repeat (3) step();
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sb", 32'(sb_cnt), 0);
      chk("rst_db", 32'(db_cnt), 0);
      chk("rst_dba", 32'(db_addr), 0);
      chk("rst_irq", 32'(db_irq), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", 32'(mem_wdata), 0);
      chk("rst_code", 32'(dec_code), 0);

      // clean memory: reads at 0,1,2,3 spaced GAP idle + 4 access cycles
      rst_n = 1'b1;
      en    = 1'b1;
      ok    = 1'b0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (rd_cnt >= 4) begin
            ok = 1'b1;
            break;
         end
      end
      chk("first_reads", 32'(ok), 1);
      for (int i = 1; i < 4; i++)
         chk("read_period", rd_t[i] - rd_t[i-1], 8);
      chk("clean_writes", wr_cnt, 0);
      wait_idle("idle0");

      foreach (tbl[i]) begin
         wait_idle("tbl_idle");
         rd0 = rd_cnt;
         wr0 = wr_cnt;
         inject(tbl[i].a, tbl[i].fa, tbl[i].fb);
         gnt_delay = tbl[i].gd;
         ok = 1'b0;
         for (int c = 0; c < 600; c++) begin
            step();
            if (rd_cnt > rd0 && last_rd_addr == tbl[i].a && !busy) begin
               ok = 1'b1;
               break;
            end
         end
         chk("tbl_timeout", 32'(ok), 1);
         chk("tbl_writes", wr_cnt - wr0, tbl[i].wr);
         chk("tbl_sb", 32'(sb_cnt), tbl[i].sb);
         chk("tbl_db", 32'(db_cnt), tbl[i].db);
         chk("tbl_dba", 32'(db_addr), tbl[i].dba);
         chk("tbl_fixed", 32'(mem[tbl[i].a] == clean[tbl[i].a]), tbl[i].fixed);
         if (tbl[i].fixed == 0) begin
            mem[tbl[i].a]   = clean[tbl[i].a];
            flips[tbl[i].a] = 0;
         end
      end

      // dropping enable mid-access still completes the write-back
      wait_idle("en_idle");
      inject(exp_addr, 6, -1);
      gnt_delay = 3;
      wr0 = wr_cnt;
      ok  = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (mem_req) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk("en_req_seen", 32'(ok), 1);
      en = 1'b0;
      step();
      wait_idle("en_complete");
      chk("en_write", wr_cnt - wr0, 1);
      rd0 = rd_cnt;
      repeat (40) step();
      chk("en_no_read", rd_cnt - rd0, 0);
      chk("en_stay_idle", 32'(busy), 0);

      // reset while a read response is outstanding
      gnt_delay = 0;
      rv_delay  = 4;
      en        = 1'b1;
      rd0       = rd_cnt;
      ok        = 1'b0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (rd_cnt > rd0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rst_read_seen", 32'(ok), 1);
      step();
      chk("rst_in_access", 32'(busy), 1);
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      chk("rst_mid_req", 32'(mem_req), 0);
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_sb", 32'(sb_cnt), 0);
      chk("rst_mid_db", 32'(db_cnt), 0);
      chk("rst_mid_addr", 32'(mem_addr), 0);
      exp_addr     = 0;
      exp_sb       = 0;
      exp_db       = 0;
      exp_dba      = 0;
      irq_hi_cnt   = 0;
      expect_write = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (8) step();
      chk("stale_rvalid_idle", 32'(busy), 0);
      chk("stale_rvalid_code", 32'(dec_code), 0);
      rv_delay = 0;
      en       = 1'b1;
      rd0      = rd_cnt;
      ok       = 1'b0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (rd_cnt > rd0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("restart_read", 32'(ok), 1);
      chk("restart_addr", last_rd_addr, 0);

      // randomized errors, handshake latencies and enable gaps
      rd0 = rd_cnt;
      for (int c = 0; c < 4000; c++) begin
         step();
         if (!busy) begin
            gnt_delay = $urandom_range(0, 3);
            rv_delay  = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) begin
               a  = $urandom_range(0, DEPTH - 1);
               n  = $urandom_range(0, 2);
               b0 = $urandom_range(0, N - 1);
               inject(a, (n >= 1) ? b0 : -1,
                      (n == 2) ? (b0 + $urandom_range(1, N - 1)) % N : -1);
            end
         end
         en = ($urandom_range(0, 9) != 0);
      end
      en = 1'b1;
      wait_idle("rand_idle");
      chk("rand_progress", 32'(rd_cnt - rd0 > 100), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 SHALL have parameter K, default 8, data bits per word.
REQ-002 SHALL have parameter M, default 4, Hamming check bits; codeword width N = K+M+1 (overall parity included).
REQ-003 SHALL have parameter AW, default 6, address width; DEPTH = 2**AW words scrubbed.
REQ-004 SHALL have parameter GAP, default 16, idle cycles between scrub accesses (GAP >= 1).
REQ-005 Ports: clk_i in 1 clock; rst_ni in 1 asynchronous active-low reset.
REQ-006 Ports: en_i in 1 scrub enable; busy_o out 1 access in progress.
REQ-007 Ports: mem_req_o out 1; mem_we_o out 1; mem_addr_o out AW; mem_wdata_o out N; mem_gnt_i in 1; mem_rvalid_i in 1; mem_rdata_i in N.
REQ-008 Ports: dec_code_o out N codeword to SECDED decoder; dec_data_i in K; dec_sb_err_i in 1; dec_db_err_i in 1 (decoder combinational).
REQ-009 Ports: enc_data_o out K data to SECDED encoder; enc_code_i in N re-encoded codeword (encoder combinational).
REQ-010 Ports: sb_cnt_o out 16; db_cnt_o out 16; db_addr_o out AW; db_irq_o out 1.

Function
REQ-011 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
REQ-012 IDLE: gap counter increments while en_i=1; on reaching GAP-1, clear counter, go RD_REQ; en_i=0 holds counter at 0.
REQ-013 RD_REQ: mem_req_o=1, mem_we_o=0, mem_addr_o=scrub address; stay until mem_gnt_i=1, then RD_WAIT.
REQ-014 RD_WAIT: on mem_rvalid_i=1 capture mem_rdata_i into codeword register, go CHECK; rvalid in gnt cycle SHALL be ignored (earliest accepted one cycle after gnt).
REQ-015 CHECK (one cycle): dec_code_o=codeword register; enc_data_o=dec_data_i.
REQ-016 CHECK, sb_err=1 and db_err=0: latch enc_code_i into write register, increment sb_cnt_o, go WR_REQ.
REQ-017 CHECK, db_err=1: increment db_cnt_o, db_addr_o<=address, pulse db_irq_o one cycle, no write-back, go NEXT; db_err dominates sb_err.
REQ-018 CHECK, no error: go NEXT.
REQ-019 WR_REQ: mem_req_o=1, mem_we_o=1, mem_wdata_o=write register, same address; stay until mem_gnt_i=1, then NEXT.
REQ-020 NEXT (one cycle): address increments, wrapping DEPTH-1 -> 0; go IDLE.
REQ-021 Both counters SHALL saturate at 16'hFFFF.
REQ-022 mem_req_o SHALL be 0 in all states except RD_REQ and WR_REQ; once asserted, req/we/addr/wdata SHALL stay stable until gnt.
REQ-023 en_i deassertion SHALL NOT abort an access in progress; FSM completes to IDLE and stays there.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 Outside CHECK, dec_code_o SHALL still equal codeword register; enc_data_o SHALL equal dec_data_i.

Reset
REQ-026 On rst_ni=0 asynchronously: state IDLE, address 0, gap counter 0, sb_cnt_o=0, db_cnt_o=0, db_addr_o=0, db_irq_o=0, mem_req_o=0, mem_we_o=0, codeword and write registers 0.
REQ-027 Reset mid-access SHALL drop mem_req_o immediately; an in-flight rvalid after release SHALL be ignored in IDLE.

Verification
REQ-028 K=8, GAP=4, clean memory, en_i=1, gnt same-cycle, rvalid one cycle later -> reads at addr 0,1,2.. every 4+4 cycles, counters stay 0, no writes.
REQ-029 Word at addr 5 with one flipped bit -> single write to addr 5 with corrected codeword, sb_cnt_o=1, next read of addr 5 clean.
REQ-030 Word at addr 9 with two flipped bits -> db_cnt_o=1, db_addr_o=9, db_irq_o one-cycle pulse, no write to addr 9.
REQ-031 AW=2, clean memory, run 6 accesses -> address sequence 0,1,2,3,0,1.
REQ-032 gnt delayed 3 cycles in RD_REQ and WR_REQ -> req/we/addr/wdata stable throughout, one access each.
REQ-033 rst_ni low during RD_WAIT, rvalid arrives after release -> outputs at reset values, rvalid ignored, scrub restarts at addr 0.
